fx2_tx_scheduler: RTL and testbench

//  Round-robin scheduler that serializes multi-byte time-tag records from N_SRC requesters

---
 rtl/fx2_tx_scheduler_pkg.sv | 23 ++
 rtl/fx2_tx_scheduler_rr_arbiter.sv | 33 +++
 rtl/fx2_tx_scheduler.sv | 142 ++++++++++++++
 tb/tb_fx2_tx_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fx2_tx_scheduler_pkg.sv
// Shared types and helpers for the FX2 transmit scheduler.
package fx2_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } sched_state_e;

  localparam logic [3:0] TAG_MAGIC = 4'hA;

  // Increment that sticks at all-ones of the given width (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic inc,
                                          input int unsigned width);
    logic [32:0] lim;
    lim = (33'd1 << width) - 33'd1;
    if (inc && ({1'b0, cnt} != lim)) begin
      return cnt + 32'd1;
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/fx2_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW-1:0] idx_s;

  // Scan from ptr upward; the first hit wins and later hits are ignored.
  always_comb begin
    grant     = {N{1'b0}};
    grant_idx = {IW{1'b0}};
    any       = 1'b0;
    idx_s     = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx_s = IW'((int'(ptr) + i) % N);
      if (!any && req[idx_s]) begin
        any          = 1'b1;
        grant_idx    = idx_s;
        grant[idx_s] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/fx2_tx_scheduler.sv
// Round-robin serializer of multi-byte records onto the FX2 byte handshake.
// Define SCHED_SRC_TAG_EN to prefix each record with a {4'hA, source} header byte.
module fx2_tx_scheduler #(
  parameter int N_SRC     = 4,
  parameter int REC_BYTES = 4,
  parameter int LEN_W     = 16
) (
  input  logic                           FX2_CLK,
  input  logic                           RESET_N,
  input  logic [N_SRC-1:0]               SRC_REQ,
  input  logic [N_SRC*REC_BYTES*8-1:0]   SRC_DATA,
  output logic [N_SRC-1:0]               SRC_ACK,
  output logic [7:0]                     FPGA_WORD,
  output logic                           FPGA_WORD_AVAILIABLE,
  input  logic                           FPGA_WORD_ACCEPTED,
  input  logic                           REQUEST_LENGTH,
  output logic [LEN_W-1:0]               LENGTH
);

  import fx2_sched_pkg::*;

  localparam int IW  = $clog2(N_SRC);
  localparam int RB8 = REC_BYTES * 8;
`ifdef SCHED_SRC_TAG_EN
  localparam int TOT = REC_BYTES + 1;
`else
  localparam int TOT = REC_BYTES;
`endif
  localparam int TOT8 = TOT * 8;
  localparam int BW   = $clog2(TOT);

  sched_state_e      state_r;
  logic [IW-1:0]     ptr_r;
  logic [TOT8-1:0]   shift_r;
  logic [7:0]        word_r;
  logic              avail_r;
  logic [N_SRC-1:0]  ack_r;
  logic [BW-1:0]     byte_idx_r;
  logic [LEN_W-1:0]  cnt_r;
  logic [LEN_W-1:0]  len_r;

  logic [N_SRC-1:0]  grant_s;
  logic [IW-1:0]     grant_idx_s;
  logic              any_s;
  logic              accepted_s;
  logic              last_s;
  logic              load_s;
  logic [TOT8-1:0]   rec_s;
  logic [LEN_W-1:0]  cnt_next_s;
  logic [IW-1:0]     ptr_next_s;

  rr_arbiter #(.N(N_SRC), .IW(IW)) u_arb (
    .req       (SRC_REQ),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any       (any_s)
  );

  assign accepted_s = avail_r & FPGA_WORD_ACCEPTED;
  assign last_s     = (byte_idx_r == BW'(TOT - 1));
  // A new record is taken either from idle or on the edge the final byte leaves, so no bubble.
  assign load_s     = any_s & ((state_r == IDLE) | ((state_r == SEND) & accepted_s & last_s));
  assign ptr_next_s = (grant_idx_s == IW'(N_SRC - 1)) ? {IW{1'b0}} : grant_idx_s + IW'(1);
  assign cnt_next_s = LEN_W'(sat_inc(32'(cnt_r), accepted_s, LEN_W));

  // Select the granted record, optionally prefixed with its source header.
  always_comb begin
    rec_s = {TOT8{1'b0}};
`ifdef SCHED_SRC_TAG_EN
    rec_s = {TAG_MAGIC, 4'(grant_idx_s), SRC_DATA[grant_idx_s*RB8 +: RB8]};
`else
    rec_s = SRC_DATA[grant_idx_s*RB8 +: RB8];
`endif
  end

  // Scheduler FSM: arbitration, record shift-out and handshake outputs.
  always_ff @(posedge FX2_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r    <= IDLE;
      ptr_r      <= {IW{1'b0}};
      shift_r    <= {TOT8{1'b0}};
      word_r     <= 8'h00;
      avail_r    <= 1'b0;
      ack_r      <= {N_SRC{1'b0}};
      byte_idx_r <= {BW{1'b0}};
    end else begin
      ack_r <= load_s ? grant_s : {N_SRC{1'b0}};
      if (load_s) begin
        state_r    <= SEND;
        avail_r    <= 1'b1;
        word_r     <= rec_s[TOT8-1 -: 8];
        shift_r    <= {rec_s[TOT8-9:0], 8'h00};
        byte_idx_r <= {BW{1'b0}};
        ptr_r      <= ptr_next_s;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
            avail_r <= 1'b0;
          end
          SEND: begin
            if (accepted_s && last_s) begin
              state_r <= IDLE;
              avail_r <= 1'b0;
              word_r  <= 8'h00;
            end else if (accepted_s) begin
              word_r     <= shift_r[TOT8-1 -: 8];
              shift_r    <= {shift_r[TOT8-9:0], 8'h00};
              byte_idx_r <= byte_idx_r + BW'(1);
            end else begin
              state_r <= SEND;
            end
          end
          default: begin
            state_r <= IDLE;
            avail_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Delivered-byte counter and the frozen snapshot handed to the bridge.
  always_ff @(posedge FX2_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_r <= {LEN_W{1'b0}};
      len_r <= {LEN_W{1'b0}};
    end else if (REQUEST_LENGTH) begin
      len_r <= cnt_next_s;
      cnt_r <= {LEN_W{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign SRC_ACK              = ack_r;
  assign FPGA_WORD            = word_r;
  assign FPGA_WORD_AVAILIABLE = avail_r;
  assign LENGTH               = len_r;

endmodule

// File: tb/tb_fx2_tx_scheduler.sv
// Directed and randomized bench for fx2_tx_scheduler with a byte-queue reference model.
module tb_fx2_tx_scheduler;

  localparam int N  = 4;
  localparam int RB = 4;
`ifdef SCHED_SRC_TAG_EN
  localparam int TOT = RB + 1;
`else
  localparam int TOT = RB;
`endif

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*32-1:0] data;
  logic [N-1:0]    SRC_ACK;
  logic [7:0]      FPGA_WORD;
  logic            FPGA_WORD_AVAILIABLE;
  logic            acc;
  logic            req_len;
  logic [15:0]     LENGTH;

  fx2_tx_scheduler #(.N_SRC(N), .REC_BYTES(RB), .LEN_W(16)) dut (
    .FX2_CLK              (clk),
    .RESET_N              (rst_n),
    .SRC_REQ              (req),
    .SRC_DATA             (data),
    .SRC_ACK              (SRC_ACK),
    .FPGA_WORD            (FPGA_WORD),
    .FPGA_WORD_AVAILIABLE (FPGA_WORD_AVAILIABLE),
    .FPGA_WORD_ACCEPTED   (acc),
    .REQUEST_LENGTH       (req_len),
    .LENGTH               (LENGTH)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: bytes still owed to the bridge, in order.
  logic [7:0] q[$];
  logic [7:0] seen[$];
  int         grants[$];
  logic [7:0] e[$];
  logic [N-1:0] exp_ack;
  int ptr_m, cnt_m, len_m;
  int ack_seen[N];

  bit auto_src;
  int p_req, p_keep, p_acc, p_len, acc_mode, len_on_cnt;
  bit force_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // Choose handshake inputs for the coming edge and predict the scheduler's reaction.
  task automatic decide();
    bit consume;
    int g, v;
    case (acc_mode)
      0:       acc = (int'($urandom_range(99)) < p_acc);
      1:       acc = !acc;
      default: acc = 1'b1;
    endcase
    consume = acc && (q.size() != 0);
    if (consume) begin
      seen.push_back(FPGA_WORD);
      void'(q.pop_front());
    end
    req_len = force_len || (consume && (cnt_m + 1 == len_on_cnt)) ||
              (int'($urandom_range(99)) < p_len);
    force_len = 1'b0;
    if (req_len) begin
      v = cnt_m + (consume ? 1 : 0);
      len_m = (v > 65535) ? 65535 : v;
      cnt_m = 0;
    end else if (consume && cnt_m < 65535) begin
      cnt_m++;
    end
    exp_ack = '0;
    if (q.size() == 0 && req != '0) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      end
      exp_ack[g] = 1'b1;
      grants.push_back(g);
`ifdef SCHED_SRC_TAG_EN
      q.push_back({4'hA, 4'(g)});
`endif
      for (int b = RB - 1; b >= 0; b--) q.push_back(data[g*32 + b*8 +: 8]);
      ptr_m = (g + 1) % N;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("ack", 32'(SRC_ACK), 32'(exp_ack));
    chk("avail", 32'(FPGA_WORD_AVAILIABLE), (q.size() != 0) ? 32'd1 : 32'd0);
    if (q.size() != 0) chk("word", 32'(FPGA_WORD), 32'(q[0]));
    chk("length", 32'(LENGTH), 32'(len_m));
    for (int i = 0; i < N; i++) begin
      if (SRC_ACK[i]) begin
        ack_seen[i]++;
        if (auto_src && int'($urandom_range(99)) < p_keep) data[i*32 +: 32] = $urandom();
        else req[i] = 1'b0;
      end
    end
    if (auto_src) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && int'($urandom_range(99)) < p_req) begin
          req[i] = 1'b1;
          data[i*32 +: 32] = $urandom();
        end
      end
    end
    decide();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ack", 32'(SRC_ACK), 32'd0);
    chk("rst_word", 32'(FPGA_WORD), 32'd0);
    chk("rst_avail", 32'(FPGA_WORD_AVAILIABLE), 32'd0);
    chk("rst_length", 32'(LENGTH), 32'd0);
    req = '0; acc = 1'b0; req_len = 1'b0; force_len = 1'b0;
    q.delete(); seen.delete(); grants.delete();
    exp_ack = '0; ptr_m = 0; cnt_m = 0; len_m = 0; len_on_cnt = -1;
    for (int i = 0; i < N; i++) ack_seen[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_seen(input string tag);
    chk({tag, "_n"}, 32'(seen.size()), 32'(e.size()));
    for (int i = 0; i < e.size(); i++)
      chk(tag, (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF, 32'(e[i]));
  endtask

  initial begin
    rst_n = 1'b0; req = '0; data = '0; acc = 1'b0; req_len = 1'b0;
    auto_src = 1'b0; p_req = 0; p_keep = 0; p_acc = 0; p_len = 0; acc_mode = 2;
    force_len = 1'b0; len_on_cnt = -1;

    // Single record from src0, accepted every cycle; first grant after reset is src0.
    do_reset();
    data[31:0] = 32'hDEAD_BEEF; req = 4'b0001;
    decide();
    repeat (TOT + 3) cycle();
    chk("first_grant", (grants.size() > 0) ? 32'(grants[0]) : 32'hFFFF_FFFF, 32'd0);
    chk("ack0_pulses", 32'(ack_seen[0]), 32'd1);
    e.delete();
`ifdef SCHED_SRC_TAG_EN
    e.push_back(8'hA0);
`endif
    e.push_back(8'hDE); e.push_back(8'hAD); e.push_back(8'hBE); e.push_back(8'hEF);
    chk_seen("deadbeef");
    force_len = 1'b1; cycle(); cycle();
    chk("len_rec", 32'(LENGTH), 32'(TOT));

    // All sources busy, toggling accept: strict 0,1,2,3,0 rotation with no gaps.
    do_reset();
    auto_src = 1'b1; p_req = 100; p_keep = 100; acc_mode = 1;
    decide();
    repeat (6 * 2 * TOT) cycle();
    chk("rr_n", (grants.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 5; i++)
      chk("rr_order", (i < grants.size()) ? 32'(grants[i]) : 32'hFFFF_FFFF, 32'(i % N));

    // Snapshot on the same edge as the third accepted byte, then the remainder.
    do_reset();
    auto_src = 1'b0; acc_mode = 2; p_req = 0; p_keep = 0;
    data[31:0] = $urandom(); req = 4'b0001; len_on_cnt = 3;
    decide();
    repeat (TOT + 3) cycle();
    chk("len_same_edge", 32'(LENGTH), 32'd3);
    len_on_cnt = -1;
    force_len = 1'b1; cycle(); cycle();
    chk("len_rest", 32'(LENGTH), 32'(TOT - 3));

    // Counter saturation after 70000 accepted bytes.
    do_reset();
    auto_src = 1'b1; p_req = 100; p_keep = 100; acc_mode = 2;
    decide();
    repeat (70000) cycle();
    force_len = 1'b1; cycle(); cycle();
    chk("len_sat", 32'(LENGTH), 32'h0000_FFFF);

    // Record from src2 alone (header byte when tagging is built in).
    do_reset();
    auto_src = 1'b0; p_req = 0; p_keep = 0; acc_mode = 2;
    data[95:64] = 32'h0102_0304; req = 4'b0100;
    decide();
    repeat (TOT + 3) cycle();
    chk("src2_grant", (grants.size() > 0) ? 32'(grants[0]) : 32'hFFFF_FFFF, 32'd2);
    e.delete();
`ifdef SCHED_SRC_TAG_EN
    e.push_back(8'hA2);
`endif
    e.push_back(8'h01); e.push_back(8'h02); e.push_back(8'h03); e.push_back(8'h04);
    chk_seen("src2");
    force_len = 1'b1; cycle(); cycle();
    chk("len_src2", 32'(LENGTH), 32'(TOT));

    // Random traffic with a reset dropped in mid-stream.
    do_reset();
    auto_src = 1'b1; p_req = 30; p_keep = 50; acc_mode = 0; p_acc = 60; p_len = 5;
    decide();
    repeat (1500) cycle();
    do_reset();
    decide();
    repeat (1500) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
